// File: rtl/harness_ctrl.sv
// Processor test-harness sequencer: reset, run for N cycles while tracing write-backs,
// then sweep every register against an expected-value ROM and count mismatches.
module harness_ctrl #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned CYC_W          = 21,
    parameter int unsigned DEFAULT_CYCLES = 5000,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned ERR_W          = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    output logic              proc_reset,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              test_mode,
    output logic [REG_AW-1:0] test_reg,
    input  logic [DATA_W-1:0] reg_data,
    output logic [REG_AW-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [REG_AW-1:0] trace_reg,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_ovf,
    output logic              fail_valid,
    output logic [REG_AW-1:0] fail_reg,
    output logic [ERR_W-1:0]  errors,
    output logic              done
);
    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    // One extra bit so the sweep index can reach NUM_REGS (the trailing compare cycle).
    localparam int unsigned IDX_W = REG_AW + 1;

    typedef enum logic [2:0] {StIdle, StClear, StRun, StCheck, StDone} state_e;

    state_e state_q, state_d;

    logic [CYC_W-1:0]  len_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [IDX_W-1:0]  chk_q;
    logic [IDX_W-1:0]  fail_idx;
    logic [DATA_W-1:0] rdata_q;
    logic [ERR_W-1:0]  err_q;
    logic              ovf_q;
    logic [PTR_W:0]    wptr_q;
    logic [PTR_W:0]    rptr_q;

    logic [CYC_W-1:0]  mem_cyc  [TRACE_DEPTH];
    logic [REG_AW-1:0] mem_reg  [TRACE_DEPTH];
    logic [DATA_W-1:0] mem_data [TRACE_DEPTH];

    logic start_ok, run_last, chk_last;
    logic empty, full, push, pop, push_ok, mismatch;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign run_last = (cyc_q == (len_q - CYC_W'(1)));
    assign chk_last = (chk_q == IDX_W'(NUM_REGS));

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign push    = (state_q == StRun) && wb_en && (wb_reg != '0);
    assign pop     = !empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push && (!full || pop);

    // Compare stage: rdata_q holds register chk_q-1, exp_data is the ROM word for it.
    assign mismatch = (state_q == StCheck) && (chk_q != '0) && (rdata_q != exp_data);
    assign fail_idx = chk_q - IDX_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StClear;
            StClear:        state_d = StRun;
            StRun:          if (run_last) state_d = StCheck;
            StCheck:        if (chk_last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        proc_reset = 1'b1;
        test_mode  = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StRun: proc_reset = 1'b0;
            StCheck: begin
                proc_reset = 1'b0;
                test_mode  = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign test_reg    = test_mode ? chk_q[REG_AW-1:0] : '0;
    assign exp_addr    = test_mode ? chk_q[REG_AW-1:0] : '0;
    assign fail_valid  = mismatch;
    assign fail_reg    = fail_idx[REG_AW-1:0];
    assign errors      = err_q;
    assign trace_ovf   = ovf_q;
    assign trace_valid = !empty;
    assign trace_cycle = mem_cyc[rptr_q[PTR_W-1:0]];
    assign trace_reg   = mem_reg[rptr_q[PTR_W-1:0]];
    assign trace_data  = mem_data[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q   <= '0;
            cyc_q   <= '0;
            chk_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            cyc_q   <= (state_q == StRun) ? cyc_q + CYC_W'(1) : '0;
            chk_q   <= (state_q == StCheck) ? chk_q + IDX_W'(1) : '0;
            rdata_q <= reg_data;
            if (start_ok) begin
                len_q  <= (num_cycles == '0) ? CYC_W'(DEFAULT_CYCLES) : num_cycles;
                err_q  <= '0;
                ovf_q  <= 1'b0;
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (mismatch && (err_q != '1)) err_q <= err_q + ERR_W'(1);
                if (push && !push_ok) ovf_q <= 1'b1;
                if (push_ok) wptr_q <= wptr_q + (PTR_W + 1)'(1);
                if (pop) rptr_q <= rptr_q + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_cyc[wptr_q[PTR_W-1:0]]  <= cyc_q;
            mem_reg[wptr_q[PTR_W-1:0]]  <= wb_reg;
            mem_data[wptr_q[PTR_W-1:0]] <= wb_data;
        end
    end

endmodule

// File: doc/harness_ctrl.md
Name: harness_ctrl

Overview:
- Synthesizable, parametrised successor to the processor test harness.
- Sequences a run: hold the processor in reset, run for N cycles, capture register write-backs into a trace FIFO, then hijack the regfile read port A to sweep every register against an expected-value ROM.
- Sits between processor, regfile and an expected-value ROM. Exposes an error count, per-register fail pulses, and a drainable write-back trace.

Parameters:
DATA_W, 32, register/data width
NUM_REGS, 32, registers swept in check phase
REG_AW, 5, register address width (2^REG_AW >= NUM_REGS)
CYC_W, 21, run-cycle counter width
DEFAULT_CYCLES, 5000, run length used when num_cycles == 0
TRACE_DEPTH, 16, trace FIFO entries (power of 2)
ERR_W, 6, error counter width (saturating)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low; clears all state
start  in  1  begin a run (accepted in IDLE or DONE)
num_cycles  in  CYC_W  run length, sampled on accepted start; 0 selects DEFAULT_CYCLES
proc_reset  out  1  active-high reset to processor/regfile
wb_en  in  1  processor regfile write enable
wb_reg  in  REG_AW  processor write register
wb_data  in  DATA_W  processor write data
test_mode  out  1  selects test_reg onto regfile read port A
test_reg  out  REG_AW  register under test
reg_data  in  DATA_W  regfile read port A data (combinational)
exp_addr  out  REG_AW  expected-value ROM address
exp_data  in  DATA_W  ROM data, registered, 1-cycle latency
trace_valid  out  1  trace head valid
trace_ready  in  1  consumer pops head when valid
trace_cycle  out  CYC_W  run cycle of traced write
trace_reg  out  REG_AW  traced register
trace_data  out  DATA_W  traced data
trace_ovf  out  1  sticky: a write-back was dropped
fail_valid  out  1  one-cycle pulse per mismatching register
fail_reg  out  REG_AW  mismatching register (valid with fail_valid)
errors  out  ERR_W  mismatch count, saturates at all-ones
done  out  1  high in DONE

Behaviour:
- Reset (reset=0, async): state IDLE; proc_reset=1; test_mode=0; test_reg=exp_addr=0; FIFO empty; trace_valid=0; trace_ovf=0; fail_valid=0; errors=0; done=0; counters=0.
- Reset asserted mid-run aborts immediately to IDLE with the same values.
- States: IDLE -> CLEAR -> RUN -> CHECK -> DONE.
- IDLE: proc_reset=1. On start: latch length L (num_cycles, or DEFAULT_CYCLES if 0); flush FIFO; clear trace_ovf and errors; go to CLEAR.
- CLEAR: exactly 1 cycle with proc_reset=1, then RUN.
- RUN: proc_reset=0; cycle counter c counts 0..L-1.
  - Each cycle with wb_en=1 and wb_reg!=0: push {c, wb_reg, wb_data}.
  - After the cycle with c=L-1: go to CHECK. RUN lasts exactly L cycles.
- Trace FIFO:
  - Push while full with no pop: drop the new entry and set trace_ovf (sticky until next start).
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pops are allowed in every state; the FIFO is not flushed on entry to CHECK or DONE.
- CHECK: test_mode=1; proc_reset=0; processor write-backs ignored. Two-stage pipeline:
  - Cycle k (0..NUM_REGS-1): test_reg=exp_addr=k; reg_data is registered at the edge ending cycle k.
  - Cycle k+1: compare the registered reg_data with exp_data (full DATA_W, bitwise). On mismatch: fail_valid=1, fail_reg=k, errors increments (saturating).
  - CHECK lasts NUM_REGS+1 cycles. Register 0 is compared like any other.
- DONE: done=1; test_mode=0; proc_reset=1; errors and trace_ovf held. start re-enters CLEAR with the same initialisation as from IDLE.
- start in CLEAR, RUN or CHECK is ignored.

Test Plan:
- Cycles and trace: reset pulse; start with num_cycles=10; processor writes r3=7 at c=2 and r5=9 at c=6 -> proc_reset high for 1 cycle, low for exactly 10; trace holds {2,3,7} then {6,5,9}; done rises 33 cycles after RUN ends.
- r0 filter: wb_en=1 with wb_reg=0 -> nothing enqueued.
- Overflow: TRACE_DEPTH=16, trace_ready=0, 20 write-backs -> 16 entries kept (first 16); trace_ovf=1.
- Full with simultaneous pop: 17th push in the same cycle as a pop -> no overflow; FIFO stays full.
- Mismatches: ROM expects r4=100 and r31=-1; regfile holds 99 and -1 -> exactly one fail_valid with fail_reg=4; errors=1.
- Default length and abort: start with num_cycles=0 -> RUN lasts 5000 cycles. Assert reset at RUN cycle 100 -> IDLE, all outputs at reset values. Subsequent start runs cleanly.
